// File: rtl/mem_port_arbiter.sv
// Shares one asynchronous-read memory port between the CPU (0) and the loader/debug port (1).
// Round-robin arbitration by default; define ARB_FIXED_PRIO_EN for fixed CPU priority.
//
// state   | meaning
// IDLE    | waiting for a request; winner and its request latched on the edge leaving here
// ACCESS  | memory driven from the latched request; read data captured at end of cycle
// DONE    | one-cycle ack to the owner, grant still held
// ILLEGAL | unused code, recovers to IDLE
module mem_port_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic          gnt0,
    output logic          gnt1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACCESS  = 2'b01,
        DONE    = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          owner;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [DW-1:0] rdata_q;
    logic          win;
    logic          any_req;
    logic          take;

    assign any_req = req0 | req1;
    assign take    = (state == IDLE) && any_req;

`ifdef ARB_FIXED_PRIO_EN
    always_comb win = ~req0;
`else
    // last holds the previous winner; reset to 1 so the CPU wins the first tie
    logic last;

    always_comb begin
        win = 1'b0;
        if (req0 && req1)
            win = ~last;
        else if (req1)
            win = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last <= 1'b1;
        else if (take)
            last <= win;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner     <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            if (take) begin
                owner     <= win;
                lat_we    <= win ? we1 : we0;
                lat_addr  <= win ? addr1 : addr0;
                lat_wdata <= win ? wdata1 : wdata0;
            end
            if (state == ACCESS && !lat_we)
                rdata_q <= mem_rdata;
        end
    end

    // outputs depend only on state and latched registers, never on req
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        mem_write = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (any_req)
                    state_nxt = ACCESS;
            end
            ACCESS: begin
                gnt0      = ~owner;
                gnt1      = owner;
                mem_write = lat_we;
                state_nxt = DONE;
            end
            DONE: begin
                gnt0      = ~owner;
                gnt1      = owner;
                ack0      = ~owner;
                ack1      = owner;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rdata     = rdata_q;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic against a
// transaction-level model (arbitration rule, reference memory, expected read data).
module tb_mem_port_arbiter;

    logic       clk;
    logic       rst;
    logic       req0, req1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       ack0, ack1, gnt0, gnt1, busy, mem_write;
    logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;

    logic [7:0] dmem    [256];
    logic [7:0] ref_mem [256];

    int n_cmp = 0;
    int n_mis = 0;

    bit         pend    [2];
    bit         p_we    [2];
    logic [7:0] p_addr  [2];
    logic [7:0] p_wdata [2];
    int         prev_win;
    logic [7:0] exp_rdata;

`ifdef ARB_FIXED_PRIO_EN
    int exp_order [4] = '{0, 0, 0, 0};
`else
    int exp_order [4] = '{0, 1, 0, 1};
`endif

    mem_port_arbiter #(.AW(8), .DW(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .gnt0(gnt0), .gnt1(gnt1),
        .rdata(rdata), .busy(busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_rdata(mem_rdata)
    );

    assign mem_rdata = dmem[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // memory write takes effect on the edge that ends the strobe cycle
    task automatic tick();
        logic       wr;
        logic [7:0] wa, wd;
        wr = mem_write;
        wa = mem_addr;
        wd = mem_wdata;
        @(posedge clk);
        if (wr === 1'b1) dmem[wa] = wd;
        #1;
    endtask

    task automatic drive();
        req0 = pend[0]; we0 = p_we[0]; addr0 = p_addr[0]; wdata0 = p_wdata[0];
        req1 = pend[1]; we1 = p_we[1]; addr1 = p_addr[1]; wdata1 = p_wdata[1];
    endtask

    task automatic set_req(input int r, input bit we, input logic [7:0] a, input logic [7:0] d);
        pend[r] = 1'b1; p_we[r] = we; p_addr[r] = a; p_wdata[r] = d;
    endtask

    function automatic int exp_winner();
`ifdef ARB_FIXED_PRIO_EN
        return pend[0] ? 0 : 1;
`else
        if (pend[0] && pend[1]) return (prev_win == 0) ? 1 : 0;
        return pend[0] ? 0 : 1;
`endif
    endfunction

    // Entered in an IDLE cycle with pending requests already driven.
    task automatic run_txn(input bit keep, input bit early, input bit n_we,
                           input logic [7:0] n_addr, input logic [7:0] n_wdata, output int got);
        int         w;
        bit         we;
        logic [7:0] a, d;
        w  = exp_winner();
        we = p_we[w];
        a  = p_addr[w];
        d  = p_wdata[w];
        prev_win = w;

        tick();
        check("acc_busy", busy, 1);
        check("acc_gnt0", gnt0, w == 0);
        check("acc_gnt1", gnt1, w == 1);
        check("acc_ack", ack0 | ack1, 0);
        check("acc_addr", mem_addr, a);
        check("acc_write", mem_write, we);
        if (we) check("acc_wdata", mem_wdata, d);
        if (early) begin
            pend[w] = 1'b0;
            drive();
        end

        tick();
        got = (ack1 === 1'b1) ? 1 : ((ack0 === 1'b1) ? 0 : -1);
        check("done_ack0", ack0, w == 0);
        check("done_ack1", ack1, w == 1);
        check("done_gnt0", gnt0, w == 0);
        check("done_gnt1", gnt1, w == 1);
        check("done_write", mem_write, 0);
        if (we) ref_mem[a] = d;
        else    exp_rdata = ref_mem[a];
        check("done_rdata", rdata, exp_rdata);
        if (keep && !early) begin
            p_we[w] = n_we; p_addr[w] = n_addr; p_wdata[w] = n_wdata;
        end else begin
            pend[w] = 1'b0;
        end
        drive();

        tick();
        check("idle_busy", busy, 0);
        check("idle_gnt", gnt0 | gnt1, 0);
        check("idle_ack", ack0 | ack1, 0);
        check("idle_write", mem_write, 0);
        check("idle_addr", mem_addr, a);
        check("mem_content", dmem[a], ref_mem[a]);
    endtask

    initial begin
        int got;
        rst = 1'b1;
        for (int r = 0; r < 2; r++) begin
            pend[r] = 1'b0; p_we[r] = 1'b0; p_addr[r] = '0; p_wdata[r] = '0;
        end
        drive();
        for (int i = 0; i < 256; i++) begin
            dmem[i]    = 8'($urandom);
            ref_mem[i] = dmem[i];
        end
        #1 rst = 1'b0;
        tick();
        tick();

        // power-up reset values
        check("rst_busy", busy, 0);
        check("rst_ack", {ack0, ack1}, 0);
        check("rst_gnt", {gnt0, gnt1}, 0);
        check("rst_write", mem_write, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_rdata", rdata, 0);

        // contention from reset, both requesters held
        prev_win  = 1;
        exp_rdata = '0;
        set_req(0, 1'($urandom), 8'($urandom), 8'($urandom));
        set_req(1, 1'($urandom), 8'($urandom), 8'($urandom));
        drive();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_txn(1'b1, 1'b0, 1'($urandom), 8'($urandom), 8'($urandom), got);
            check("order", got, exp_order[i]);
        end
        pend[0] = 1'b0; pend[1] = 1'b0;
        drive();
        tick();
        check("cont_idle", busy, 0);

        // reset asserted during a write access
        dmem[8'h10] = 8'h5A; ref_mem[8'h10] = 8'h5A;
        set_req(0, 1'b1, 8'h10, 8'hA5);
        drive();
        tick();
        check("mw_strobe", mem_write, 1);
        #2 rst = 1'b0;
        #1;
        check("mw_write_drop", mem_write, 0);
        check("mw_busy", busy, 0);
        check("mw_ack", ack0, 0);
        pend[0] = 1'b0;
        drive();
        prev_win  = 1;
        exp_rdata = '0;
        tick();
        check("mw_ack_hold", ack0, 0);
        rst = 1'b1;
        tick();
        check("mw_ack_after", ack0, 0);
        tick();
        check("mw_mem", dmem[8'h10], 8'h5A);
        check("mw_rdata", rdata, 0);

        // single read from CPU
        dmem[8'h20] = 8'h3C; ref_mem[8'h20] = 8'h3C;
        set_req(0, 1'b0, 8'h20, 8'h00);
        drive();
        run_txn(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, got);
        check("rd_owner", got, 0);
        check("rd_val", rdata, 8'h3C);

        // single write from loader, then read back
        set_req(1, 1'b1, 8'hFF, 8'h81);
        drive();
        run_txn(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, got);
        check("wr_owner", got, 1);
        check("wr_mem", dmem[8'hFF], 8'h81);
        check("wr_rdata_kept", rdata, 8'h3C);
        set_req(0, 1'b0, 8'hFF, 8'h00);
        drive();
        run_txn(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, got);
        check("wr_readback", rdata, 8'h81);

        // loader drops request during access
        set_req(1, 1'b0, 8'h05, 8'h00);
        drive();
        run_txn(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, got);
        check("drop_owner", got, 1);
        check("drop_rdata", rdata, ref_mem[8'h05]);
        tick();
        check("drop_idle", busy, 0);

        // back-to-back CPU reads, address changed right after ack
        set_req(0, 1'b0, 8'h01, 8'h00);
        drive();
        run_txn(1'b1, 1'b0, 1'b0, 8'h02, 8'h00, got);
        check("b2b_first", rdata, ref_mem[8'h01]);
        run_txn(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, got);
        check("b2b_owner", got, 0);
        check("b2b_second", rdata, ref_mem[8'h02]);

        // random traffic
        for (int n = 0; n < 200; n++) begin
            for (int r = 0; r < 2; r++)
                if (!pend[r] && $urandom_range(0, 99) < 60)
                    set_req(r, 1'($urandom), 8'($urandom), 8'($urandom));
            drive();
            if (!pend[0] && !pend[1]) begin
                tick();
                check("rnd_idle", busy, 0);
            end else begin
                run_txn(1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                        1'($urandom), 8'($urandom), 8'($urandom), got);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
